// File: rtl/dec_accum_s.sv
// Serial signed decimal-to-binary converter: one BCD digit per handshake, MS digit first,
// with saturation to the signed W-bit range and an error flag for non-decimal digits.
module dec_accum_s #(
   parameter int W    = 16,
   parameter int NDIG = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         neg,
   input  logic         digit_valid,
   input  logic [3:0]   digit,
   input  logic         last,
   output logic         digit_ready,
   output logic [W-1:0] result,
   output logic         result_valid,
   input  logic         result_ready,
   output logic         ovf,
   output logic         err
);

   localparam int CW = $clog2(NDIG + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_r, state_nxt_s;
   logic [W-1:0]   acc_r, acc_nxt_s;
   logic [CW-1:0]  cnt_r, cnt_nxt_s;
   logic           neg_r, neg_nxt_s;
   logic           ovf_r, ovf_nxt_s;
   logic           err_r, err_nxt_s;
   logic [W-1:0]   result_r, result_nxt_s;
   logic           digit_ready_r;
   logic           result_valid_r;
   logic [W+3:0]   sum_s;
   logic [W+3:0]   lim_s;

   // x10 as (acc<<3)+(acc<<1) plus the digit, four guard bits so nothing wraps
   assign sum_s = {1'b0, acc_r, 3'b000} + {3'b000, acc_r, 1'b0} + {{W{1'b0}}, digit};
   // Negative numbers may reach one further: |most-negative| = 2^(W-1)
   assign lim_s = {5'b00000, {(W-1){1'b1}}} + {{(W+3){1'b0}}, neg_r};

   // Next-state and datapath update
   always_comb begin
      state_nxt_s = state_r;
      acc_nxt_s   = acc_r;
      cnt_nxt_s   = cnt_r;
      neg_nxt_s   = neg_r;
      ovf_nxt_s   = ovf_r;
      err_nxt_s   = err_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               acc_nxt_s   = {W{1'b0}};
               cnt_nxt_s   = {CW{1'b0}};
               neg_nxt_s   = neg;
               ovf_nxt_s   = 1'b0;
               err_nxt_s   = 1'b0;
               state_nxt_s = ACC;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACC: begin
            if (digit_valid && digit_ready_r) begin
               if (digit > 4'd9) begin
                  err_nxt_s   = 1'b1;
                  state_nxt_s = DONE;
               end else begin
                  if (sum_s > lim_s) begin
                     acc_nxt_s = lim_s[W-1:0];
                     ovf_nxt_s = 1'b1;
                  end else begin
                     acc_nxt_s = sum_s[W-1:0];
                  end
                  cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                  if (last || (cnt_r == CW'(NDIG - 1))) begin
                     state_nxt_s = DONE;
                  end else begin
                     state_nxt_s = ACC;
                  end
               end
            end else begin
               state_nxt_s = ACC;
            end
         end
         DONE: begin
            if (result_ready) begin
               // A start arriving with the result handshake begins the next number at once
               if (start) begin
                  acc_nxt_s   = {W{1'b0}};
                  cnt_nxt_s   = {CW{1'b0}};
                  neg_nxt_s   = neg;
                  ovf_nxt_s   = 1'b0;
                  err_nxt_s   = 1'b0;
                  state_nxt_s = ACC;
               end else begin
                  state_nxt_s = IDLE;
               end
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Result is captured only on the transition into DONE
   always_comb begin
      result_nxt_s = result_r;
      if ((state_r == ACC) && (state_nxt_s == DONE)) begin
         if (err_nxt_s) begin
            result_nxt_s = {W{1'b0}};
         end else if (neg_r) begin
            result_nxt_s = {W{1'b0}} - acc_nxt_s;
         end else begin
            result_nxt_s = acc_nxt_s;
         end
      end else begin
         result_nxt_s = result_r;
      end
   end

   // State, datapath and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= IDLE;
         acc_r          <= {W{1'b0}};
         cnt_r          <= {CW{1'b0}};
         neg_r          <= 1'b0;
         ovf_r          <= 1'b0;
         err_r          <= 1'b0;
         result_r       <= {W{1'b0}};
         digit_ready_r  <= 1'b0;
         result_valid_r <= 1'b0;
      end else begin
         state_r        <= state_nxt_s;
         acc_r          <= acc_nxt_s;
         cnt_r          <= cnt_nxt_s;
         neg_r          <= neg_nxt_s;
         ovf_r          <= ovf_nxt_s;
         err_r          <= err_nxt_s;
         result_r       <= result_nxt_s;
         digit_ready_r  <= (state_nxt_s == ACC);
         result_valid_r <= (state_nxt_s == DONE);
      end
   end

   assign digit_ready  = digit_ready_r;
   assign result_valid = result_valid_r;
   assign result       = result_r;
   assign ovf          = ovf_r;
   assign err          = err_r;

endmodule

// File: tb/tb_dec_accum_s.sv
// Scoreboard bench for dec_accum_s (W=16, NDIG=5): expected results are queued at stimulus
// time and popped by a monitor on each result handshake.
module tb_dec_accum_s;

   localparam int W    = 16;
   localparam int NDIG = 5;

   logic          clk;
   logic          rst;
   logic          start;
   logic          neg;
   logic          digit_valid;
   logic [3:0]    digit;
   logic          last;
   logic          digit_ready;
   logic [W-1:0]  result;
   logic          result_valid;
   logic          result_ready;
   logic          ovf;
   logic          err;

   typedef struct {
      logic [W-1:0] res;
      logic         ovf;
      logic         err;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   dec_accum_s #(.W(W), .NDIG(NDIG)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .neg          (neg),
      .digit_valid  (digit_valid),
      .digit        (digit),
      .last         (last),
      .digit_ready  (digit_ready),
      .result       (result),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .ovf          (ovf),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [W-1:0] r, input logic o, input logic e);
      exp_t x;
      x.res = r;
      x.ovf = o;
      x.err = e;
      exp_q.push_back(x);
   endtask

   // Monitor: compare every delivered result against the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && result_valid && result_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_result: got 0x%0h, expected none", result);
         end else begin
            exp_t x;
            x = exp_q.pop_front();
            check("result", {16'h0000, result}, {16'h0000, x.res});
            check("ovf", {31'd0, ovf}, {31'd0, x.ovf});
            check("err", {31'd0, err}, {31'd0, x.err});
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic n);
      start = 1'b1;
      neg   = n;
      tick();
      start = 1'b0;
      neg   = 1'b0;
   endtask

   task automatic send_digit(input logic [3:0] d, input logic l);
      int n;
      n = 0;
      digit_valid = 1'b1;
      digit       = d;
      last        = l;
      while (!digit_ready && n < 20) begin
         tick();
         n++;
      end
      if (!digit_ready) begin
         n_cmp++;
         n_fail++;
         $display("FAIL digit_ready_timeout: got 0, expected 1");
      end
      tick();
      digit_valid = 1'b0;
      last        = 1'b0;
      digit       = 4'd0;
   endtask

   task automatic send_number(input logic n, input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] d2, input logic [3:0] d3, input logic [3:0] d4,
                              input int cnt, input bit use_last);
      logic [3:0] ds [5];
      ds[0] = d0; ds[1] = d1; ds[2] = d2; ds[3] = d3; ds[4] = d4;
      do_start(n);
      for (int i = 0; i < cnt; i++) begin
         send_digit(ds[i], use_last && (i == cnt - 1));
      end
      check("valid_latency", {31'd0, result_valid}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      neg          = 1'b0;
      digit_valid  = 1'b0;
      digit        = 4'd0;
      last         = 1'b0;
      result_ready = 1'b1;
      repeat (3) tick();
      check("rst_digit_ready", {31'd0, digit_ready}, 32'd0);
      check("rst_result_valid", {31'd0, result_valid}, 32'd0);
      check("rst_result", {16'h0000, result}, 32'd0);
      check("rst_ovf_err", {30'd0, ovf, err}, 32'd0);
      rst = 1'b0;
      tick();

      // 32767 exactly
      push_exp(16'd32767, 1'b0, 1'b0);
      send_number(1'b0, 4'd3, 4'd2, 4'd7, 4'd6, 4'd7, 5, 1'b1);
      tick();
      // -32768 fits, +32768 saturates
      push_exp(16'h8000, 1'b0, 1'b0);
      send_number(1'b1, 4'd3, 4'd2, 4'd7, 4'd6, 4'd8, 5, 1'b1);
      tick();
      push_exp(16'd32767, 1'b1, 1'b0);
      send_number(1'b0, 4'd3, 4'd2, 4'd7, 4'd6, 4'd8, 5, 1'b1);
      tick();
      // -32769 saturates to most-negative
      push_exp(16'h8000, 1'b1, 1'b0);
      send_number(1'b1, 4'd3, 4'd2, 4'd7, 4'd6, 4'd9, 5, 1'b1);
      tick();
      // NDIG terminates without last
      push_exp(16'd32767, 1'b1, 1'b0);
      send_number(1'b0, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 5, 1'b0);
      tick();
      // leading zeros, -123
      push_exp(16'hFF85, 1'b0, 1'b0);
      send_number(1'b1, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 5, 1'b1);
      tick();
      // -0 is 0
      push_exp(16'd0, 1'b0, 1'b0);
      send_number(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1, 1'b1);
      tick();
      // illegal digit
      push_exp(16'd0, 1'b0, 1'b1);
      send_number(1'b1, 4'd4, 4'hA, 4'd0, 4'd0, 4'd0, 2, 1'b0);
      tick();
      do_start(1'b0);
      check("err_cleared", {31'd0, err}, 32'd0);
      push_exp(16'd1, 1'b0, 1'b0);
      send_digit(4'd1, 1'b1);
      tick();

      // held result under back-pressure, then start with the handshake
      result_ready = 1'b0;
      push_exp(16'd5, 1'b0, 1'b0);
      send_number(1'b0, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 1, 1'b1);
      digit_valid = 1'b1;
      digit       = 4'd3;
      for (int i = 0; i < 10; i++) begin
         check("hold_valid", {31'd0, result_valid}, 32'd1);
         check("hold_result", {16'h0000, result}, 32'd5);
         check("hold_digit_ready", {31'd0, digit_ready}, 32'd0);
         tick();
      end
      digit_valid  = 1'b0;
      result_ready = 1'b1;
      start        = 1'b1;
      tick();
      start = 1'b0;
      check("restart_digit_ready", {31'd0, digit_ready}, 32'd1);
      check("restart_valid_low", {31'd0, result_valid}, 32'd0);
      push_exp(16'd2, 1'b0, 1'b0);
      send_digit(4'd2, 1'b1);
      tick();

      // reset mid-number abandons it
      do_start(1'b0);
      send_digit(4'd1, 1'b0);
      send_digit(4'd2, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_digit_ready", {31'd0, digit_ready}, 32'd0);
      check("mid_rst_valid", {31'd0, result_valid}, 32'd0);
      check("mid_rst_result", {16'h0000, result}, 32'd0);
      check("mid_rst_ovf_err", {30'd0, ovf, err}, 32'd0);
      push_exp(16'd7, 1'b0, 1'b0);
      send_number(1'b0, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 1, 1'b1);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         tick();
      end
      check("scoreboard_empty", exp_q.size(), 32'd0);
      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
